// File: rtl/echo_delay_proc.sv
// Single-tap echo/delay processor between the ADC sample strobe and the DAC register.
// Each sample runs IDLE -> READ -> CALC -> WRITE around a one-cycle-latency delay RAM.
module echo_delay_proc #(
    parameter int              DW          = 10,
    parameter int              AW          = 13,
    parameter int              SW_W        = 9,
    parameter int              DELAY_SHIFT = 4,
    parameter logic [DW-1:0]   ADC_OFFSET  = 10'h181,
    parameter logic [DW-1:0]   DAC_OFFSET  = 10'h200
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               data_valid,
    input  logic [DW-1:0]      data_in,
    input  logic [SW_W-1:0]    delay_sel,
    input  logic [1:0]         mode,
    input  logic [1:0]         gain_shift,
    output logic [DW-1:0]      data_out,
    output logic               out_valid,
    output logic [AW-1:0]      delay_samples,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        CALC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'b00,
        MODE_FEEDFWD  = 2'b01,
        MODE_FEEDBACK = 2'b10,
        MODE_DELAY    = 2'b11
    } mode_t;

    localparam logic [31:0] DELAY_MAX = (32'd1 << AW) - 32'd1;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q, sync3_q;
    logic                  strobe;

    logic                  captureEn, readEn, calcEn, writeEn, dropEn;

    logic signed [DW-1:0]  x_q;
    mode_t                 mode_q;
    logic [1:0]            gain_q;
    logic [AW-1:0]         delaySamples_q;
    logic signed [DW-1:0]  y_q, y_d;
    logic [AW-1:0]         wrPtr_q;
    logic [AW-1:0]         fill_q;
    logic [DW-1:0]         dataOut_q;
    logic                  outValid_q;
    logic                  overrun_q;

    logic [DW-1:0]         mem [0:(1<<AW)-1];
    logic [DW-1:0]         ramQ_q;
    logic [AW-1:0]         rdAddr;
    logic [DW-1:0]         ramWData;

    logic [31:0]           delayWide;
    logic [AW-1:0]         delayClamped;
    logic signed [DW-1:0]  xIn;
    logic                  tapValid;
    logic signed [DW-1:0]  tapIn;
    logic signed [DW-1:0]  tap;
    logic signed [DW:0]    sum;
    logic signed [DW-1:0]  satSum;

    // Three-flop synchroniser; a new sample is the rising edge seen between stages 2 and 3.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= data_valid;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign strobe = sync2_q & ~sync3_q;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (strobe) state_d = READ;
            READ:    state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        captureEn = 1'b0;
        readEn    = 1'b0;
        calcEn    = 1'b0;
        writeEn   = 1'b0;
        dropEn    = 1'b0;
        case (state_q)
            IDLE:    captureEn = strobe;
            READ:    begin readEn  = 1'b1; dropEn = strobe; end
            CALC:    begin calcEn  = 1'b1; dropEn = strobe; end
            WRITE:   begin writeEn = 1'b1; dropEn = strobe; end
            default: captureEn = 1'b0;
        endcase
    end

    // Delay request is clamped to the deepest tap the RAM can hold.
    assign delayWide    = 32'(delay_sel) << DELAY_SHIFT;
    assign delayClamped = (delayWide > DELAY_MAX) ? AW'(DELAY_MAX) : AW'(delayWide);
    assign xIn          = data_in - ADC_OFFSET;

    assign rdAddr   = wrPtr_q - delaySamples_q;
    assign ramWData = (mode_q == MODE_FEEDBACK) ? y_q : x_q;

    always_ff @(posedge sysclk) begin
        if (writeEn) begin
            mem[wrPtr_q] <= ramWData;
        end
        if (readEn) begin
            ramQ_q <= mem[rdAddr];
        end
    end

    // Locations not yet written since reset are masked so stale RAM never reaches the DAC.
    assign tapValid = (delaySamples_q != '0) && (fill_q >= delaySamples_q);
    assign tapIn    = tapValid ? ramQ_q : '0;
    assign tap      = tapIn >>> gain_q;
    assign sum      = {x_q[DW-1], x_q} + {tap[DW-1], tap};

    always_comb begin
        satSum = sum[DW-1:0];
        if (sum[DW] != sum[DW-1]) begin
            satSum = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        y_d = x_q;
        case (mode_q)
            MODE_BYPASS:   y_d = x_q;
            MODE_FEEDFWD:  y_d = satSum;
            MODE_FEEDBACK: y_d = satSum;
            MODE_DELAY:    y_d = tapIn;
            default:       y_d = x_q;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q            <= '0;
            mode_q         <= MODE_BYPASS;
            gain_q         <= '0;
            delaySamples_q <= '0;
            y_q            <= '0;
            wrPtr_q        <= '0;
            fill_q         <= '0;
            dataOut_q      <= DAC_OFFSET;
            outValid_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            outValid_q <= writeEn;
            if (captureEn) begin
                x_q            <= xIn;
                mode_q         <= mode_t'(mode);
                gain_q         <= gain_shift;
                delaySamples_q <= delayClamped;
            end
            if (calcEn) begin
                y_q <= y_d;
            end
            if (writeEn) begin
                wrPtr_q   <= wrPtr_q + 1'b1;
                dataOut_q <= y_q + DAC_OFFSET;
                if (fill_q != '1) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            if (dropEn) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign data_out      = dataOut_q;
    assign out_valid     = outValid_q;
    assign delay_samples = delaySamples_q;
    assign overrun       = overrun_q;

endmodule
